// File: rtl/axi_uart_bridge.sv
// AXI4-Lite slave exposing one 8N1 UART as TXDATA (0x0), RXDATA (0x4) and STATUS (0x8).
// TX and RX run independently; RX input is double-flopped before use.
module axi_uart_bridge #(
    parameter int unsigned CLOCK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      uart_tx,
    input  logic                      uart_rx
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT   = CW'(CLKS_PER_BIT / 2);
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // AXI write/read channel registers
    logic                      awready_q, awready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      rd_rx_q, rd_rx_d;

    // TX path
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    // RX path
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;

    logic       wr_hs, rd_hs, tx_busy, tx_start, rx_clear;
    logic [3:0] wr_addr, rd_addr;
    logic       unused_bits;

    assign wr_addr  = s_axi_awaddr[3:0];
    assign rd_addr  = s_axi_araddr[3:0];
    assign wr_hs    = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_hs    = arready_q & s_axi_arvalid;
    assign tx_busy  = (tx_state_q != TX_IDLE);
    assign tx_start = wr_hs && (wr_addr == 4'h0) && !tx_busy;
    assign rx_clear = rvalid_q & s_axi_rready & rd_rx_q;

    assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_araddr[AXI_ADDR_WIDTH-1:4],
                           s_axi_wdata[AXI_DATA_WIDTH-1:8]};

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign uart_tx       = tx_line_q;

    // Write channel: one-cycle AW/W ready pulse, then B held until accepted
    always_comb begin
        awready_d = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = tx_start ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read channel: one-cycle AR ready pulse, then registered R held until accepted
    always_comb begin
        arready_d = s_axi_arvalid && !rvalid_q && !arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_rx_d   = rd_rx_q;
        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
            rd_rx_d  = 1'b0;
        end
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            rd_rx_d  = (rd_addr == 4'h4);
            case (rd_addr)
                4'h0:    ;
                4'h4:    rdata_d[7:0] = rx_data_q;
                4'h8:    rdata_d[1:0] = {rx_valid_q, tx_busy};
                default: rresp_d = RESP_SLVERR;
            endcase
        end
    end

    // AXI channel state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_rx_q   <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rd_rx_q   <= rd_rx_d;
        end
    end

    // TX next state: line value is computed for the next state so uart_tx is a clean flop output
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (tx_start) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = s_axi_wdata[7:0];
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                tx_line_d = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // RX next state; a completing byte is applied after the read-clear so it wins a collision
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (rx_clear) begin
            rx_valid_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_BIT) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX synchronizer and state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
endmodule

// File: tb/tb_axi_uart_bridge.sv
// Scoreboard bench for axi_uart_bridge: AXI responses and UART TX bytes are queued when
// stimulus is issued and compared when the DUT produces them.
module tb_axi_uart_bridge;
    localparam int unsigned CLK_HZ = 1_700_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned CPB    = CLK_HZ / BAUD;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [1:0]  wr_exp_q[$];
    logic [33:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    axi_uart_bridge #(
        .CLOCK_FREQ(CLK_HZ),
        .BAUD_RATE(BAUD),
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
        int n;
        wr_exp_q.push_back(exp_resp);
        @(negedge clk);
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        check("aw_w_ready", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_pulse_one_cycle", {awready, wready}, 2'b00);
        repeat (2) @(negedge clk);
        check("bvalid_hold", bvalid, 1'b1);
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("bvalid", bvalid, 1'b1);
        check("bresp", bresp, wr_exp_q.pop_front());
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, output logic [31:0] data);
        int n;
        rd_exp_q.push_back({exp_resp, exp_data});
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("arready", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("rvalid", rvalid, 1'b1);
        check($sformatf("rd_0x%0h", addr), {rresp, rdata}, rd_exp_q.pop_front());
        data = rdata;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_drop", rvalid, 1'b0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_bits(input int unsigned nbits);
        repeat (nbits * CPB) @(negedge clk);
    endtask

    // UART TX monitor: decodes each frame mid-bit and pops the expected byte
    initial begin
        logic [7:0] b;
        wait (resetn === 1'b1);
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(negedge clk);
            check("tx_start_bit", uart_tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            check("tx_stop_bit", uart_tx, 1'b1);
            if (tx_exp_q.size() == 0) check("tx_unexpected_frame", {56'h0, b}, 64'h100);
            else check("tx_byte", b, tx_exp_q.pop_front());
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [7:0] lb [5];
        lb = '{8'h00, 8'hFF, 8'hAA, 8'h55, 8'h33};

        repeat (5) @(negedge clk);
        check("reset_outputs",
              {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, uart_tx}, 42'h1);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Reset status and basic decode
        axi_read(32'h8, 32'h0, OKAY, rd);
        axi_read(32'h0, 32'h0, OKAY, rd);

        // TX of 0xA5 with busy window
        tx_exp_q.push_back(8'hA5);
        axi_write(32'h0, 32'h0000_00A5, OKAY);
        axi_read(32'h8, 32'h1, OKAY, rd);
        wait_bits(12);
        axi_read(32'h8, 32'h0, OKAY, rd);

        // RX of 0x5A, flag cleared by RXDATA read
        send_rx(8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        axi_read(32'h8, 32'h2, OKAY, rd);
        axi_read(32'h4, 32'h5A, OKAY, rd);
        axi_read(32'h8, 32'h0, OKAY, rd);

        // Loopback
        foreach (lb[i]) begin
            send_rx(lb[i], 1'b1);
            repeat (10) @(negedge clk);
            axi_read(32'h4, {24'h0, lb[i]}, OKAY, rd);
            tx_exp_q.push_back(lb[i]);
            axi_write(32'h0, rd, OKAY);
            wait_bits(12);
        end

        // Bad addresses and read-only registers
        axi_read(32'hC, 32'h0, SLVERR, rd);
        axi_write(32'h8, 32'hFFFF_FFFF, SLVERR);
        axi_write(32'h4, 32'h0000_0012, SLVERR);
        axi_read(32'h8, 32'h0, OKAY, rd);
        axi_read(32'hFFFF_FFF8, 32'h0, OKAY, rd);

        // Overrun: second byte overwrites, flag stays set
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        axi_read(32'h1000_0008, 32'h2, OKAY, rd);
        axi_read(32'h4, 32'h22, OKAY, rd);

        // False start glitch and framing error leave no flag
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        wait_bits(12);
        axi_read(32'h8, 32'h0, OKAY, rd);
        send_rx(8'h77, 1'b0);
        wait_bits(2);
        axi_read(32'h8, 32'h0, OKAY, rd);

        // Back-to-back TX writes: second dropped
        tx_exp_q.push_back(8'h3C);
        axi_write(32'h0, 32'h0000_003C, OKAY);
        axi_write(32'h0, 32'h0000_00C3, SLVERR);
        wait_bits(15);
        axi_read(32'h8, 32'h0, OKAY, rd);

        check("tx_pending", tx_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
